// File: rtl/i2s_rx_capture.sv
// rtl/i2s_rx_capture.sv - I2S capture receiver with clock generation and valid/ready frame handoff
// Optional mono downmix of each frame when I2S_RX_MONO_MIX_EN is defined.
module i2s_rx_capture #(
  parameter logic [3:0] SAMPLE_PHASE = 4'd8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        audio_mclk,
  output logic        audio_lrck,
  output logic        audio_sck,
  input  logic        audio_sdout,
  output logic [15:0] sample_left,
  output logic [15:0] sample_right,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        overrun
);

  typedef enum logic {SYNC, RUN} state_t;

  state_t      state;
  logic [8:0]  clk_cnt;
  logic [15:0] left_asm;
  logic [15:1] right_asm;
  logic [4:0]  slot;
  logic [3:0]  bit_idx;
  logic        capture;
  logic        is_left;
  logic [15:0] frame_l;
  logic [15:0] frame_r;
  logic [15:0] load_l;
  logic [15:0] load_r;

  assign audio_mclk = clk_cnt[1];
  assign audio_sck  = clk_cnt[3];
  assign audio_lrck = clk_cnt[8];

  assign slot    = clk_cnt[8:4];
  assign capture = (clk_cnt[3:0] == SAMPLE_PHASE);
  // 16 - slot for left slots 1..16 and 32 - slot for right slots 17..31 share the same low nibble.
  assign bit_idx = 4'd0 - slot[3:0];
  assign is_left = (!slot[4] && slot != 5'd0) || (slot == 5'd16);

  // Right LSB arrives in slot 0 of the next period and is folded in on the load edge itself.
  assign frame_l = left_asm;
  assign frame_r = {right_asm, audio_sdout};

`ifdef I2S_RX_MONO_MIX_EN
  logic [16:0] mix_sum;
  assign mix_sum = {frame_l[15], frame_l} + {frame_r[15], frame_r};
  assign load_l  = mix_sum[16:1];
  assign load_r  = mix_sum[16:1];
`else
  assign load_l  = frame_l;
  assign load_r  = frame_r;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt <= '0;
    end else begin
      clk_cnt <= clk_cnt + 9'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SYNC;
      left_asm     <= '0;
      right_asm    <= '0;
      sample_left  <= '0;
      sample_right <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
      if (capture) begin
        case (state)
          SYNC: begin
            if (slot == 5'd1) begin
              left_asm[15] <= audio_sdout;
              state        <= RUN;
            end
          end
          RUN: begin
            if (slot == 5'd0) begin
              sample_left  <= load_l;
              sample_right <= load_r;
              sample_valid <= 1'b1;
              if (sample_valid && !sample_ready) begin
                overrun <= 1'b1;
              end
            end else if (is_left) begin
              left_asm[bit_idx] <= audio_sdout;
            end else begin
              right_asm[bit_idx] <= audio_sdout;
            end
          end
          default: state <= SYNC;
        endcase
      end
    end
  end

endmodule

// File: doc/i2s_rx_capture.md
Name: i2s_rx_capture

Overview:
- I2S receiver for the line-in / microphone ADC path; the capture-side counterpart of the speaker-side serializer.
- Generates the master, bit and word clocks itself from the crystal clock.
- Deserializes the ADC's audio_sdout into 16-bit left/right samples.
- Hands each completed stereo frame to downstream logic over a valid/ready interface, with sticky overrun detection.

Parameters:
- SAMPLE_PHASE, 4'd8: value of clk_cnt[3:0] in the cycle whose closing clk edge captures audio_sdout. 8 = first clk cycle after audio_sck rises.

Ports:
- clk  input  1  crystal clock; only clock in the block
- rst_n  input  1  reset, asynchronous assert, active low
- audio_mclk  output  1  master clock = clk_cnt[1]
- audio_lrck  output  1  word select = clk_cnt[8]; 0 = left, 1 = right
- audio_sck  output  1  serial bit clock = clk_cnt[3]
- audio_sdout  input  1  serial data from ADC, MSB first, I2S one-bit delay
- sample_left  output  16  last completed left sample, two's complement
- sample_right  output  16  last completed right sample, two's complement
- sample_valid  output  1  frame in sample_left/right not yet accepted
- sample_ready  input  1  consumer accepts frame at clk edge when sample_valid=1
- overrun  output  1  sticky: a frame was overwritten before acceptance

Behaviour:
- Reset (rst_n=0, async):
  - clk_cnt (9-bit free-running) = 0
  - shift/assembly registers, sample_left, sample_right = 0
  - sample_valid = 0, overrun = 0, FSM = SYNC
- Counter: clk_cnt increments by 1 every clk and wraps 511 -> 0. Frame period = 512 clk; 32 bit slots of 16 clk; slot = clk_cnt[8:4].
- Capture edge: the clk edge ending a cycle with clk_cnt[3:0] == SAMPLE_PHASE. audio_sdout is sampled directly there (source-synchronous with audio_sck, no synchronizer).
- Slot mapping:
  - slot 1..16 -> left[15..0]
  - slot 17..31 -> right[15..1]
  - slot 0 -> right[0] of the frame begun in the previous period
- FSM SYNC:
  - Captures are discarded.
  - At the slot-1 capture edge, store the bit as left[15] and go to RUN.
- FSM RUN:
  - Every capture edge writes its bit position.
  - At the slot-0 capture edge, the frame is complete: load sample_left/right with the full frame, including the bit captured at this edge.
  - On that load: sample_valid <= 1; if sample_valid=1 and sample_ready=0 at this edge, set overrun.
- Startup timing: cycle k after reset release has clk_cnt = k mod 512. With SAMPLE_PHASE=8:
  - first slot-1 capture ends cycle 24
  - first load ends cycle 520, so sample_valid=1 from cycle 521
  - later frames load every 512 cycles
- Handshake:
  - sample_valid && sample_ready at an edge clears sample_valid next cycle, unless a load occurs at the same edge.
  - Load and accept at the same edge: sample_valid stays 1 with new data; no overrun.
  - sample_left/right change only on a load; they are stable while sample_valid=1 and no load occurs.
  - sample_ready while sample_valid=0 is ignored.
- overrun clears only on reset.
- Reset mid-frame: all state clears immediately; the partial frame is lost; the block re-enters SYNC.

Optional Feature:
- Macro: I2S_RX_MONO_MIX_EN
- Defined: at load, both sample_left and sample_right = (sext17(L) + sext17(R)) >>> 1, truncated to 16 bits (arithmetic shift; no overflow possible). Timing and handshake are unchanged.
- Undefined: raw L and R are presented separately.

Test Plan:
- Reset release, audio_sdout=0 -> sample_valid first rises in cycle 521; outputs 0; rises again 512 cycles later; mclk/sck/lrck periods are 4/16/512 clk.
- ADC model sends L=16'hA5C3, R=16'h7FFE with one-bit delay, sample_ready=1 -> sample_left=16'hA5C3, sample_right=16'h7FFE, sample_valid is a 1-cycle pulse per frame.
- sample_ready held 0 for two frames (L=16'h0001 then 16'h0002) -> after second load sample_left=16'h0002 and overrun=1, held until reset.
- sample_ready asserted exactly at the load edge -> no overrun, sample_valid stays 1, new data present.
- rst_n pulsed low at clk_cnt=300 -> outputs 0 immediately; next valid at 521 cycles after release.
- I2S_RX_MONO_MIX_EN defined, L=16'h8000, R=16'h7FFF -> both outputs 16'hFFFF; L=R=16'h4000 -> both 16'h4000.
